// File: rtl/demux_pkg.sv
// demux_pkg: default word and select widths shared across the processor datapath
package demux_pkg;
  localparam int ANCHO_DEF = 9;
  localparam int N_DEF = 2;
endpackage

// File: rtl/canal_retencion.sv
// canal_retencion: one-entry holding register with valid/consume handshake
//   clk, rst         clock, asynchronous active-high reset
//   carga            load entrada this edge (wins over consumo)
//   consumo          consumer takes the held word this edge
//   entrada          word to load
//   dato, valido     held word (zero when empty) and its valid flag
//   libre            register can accept a load this cycle
module canal_retencion #(
  parameter int ANCHO = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             carga,
  input  logic             consumo,
  input  logic [ANCHO-1:0] entrada,
  output logic [ANCHO-1:0] dato,
  output logic             valido,
  output logic             libre
);
  typedef enum logic {VACIO, LLENO} estado_t;
  estado_t estado;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      estado <= VACIO;
      dato   <= '0;
    end else if (carga) begin
      estado <= LLENO;
      dato   <= entrada;
    end else if (consumo && estado == LLENO) begin
      estado <= VACIO;
      dato   <= '0;
    end
  assign valido = estado == LLENO;
  // a full register that is consumed this cycle can take a new word on the same edge
  assign libre = !valido || consumo;
endmodule

// File: rtl/demux_registrado.sv
// demux_registrado: registered, handshaked demultiplexor with broadcast and discard counter
//   Entrada/SEL/modo_difusion/entrada_valida  input word, destination, broadcast, valid
//   entrada_lista                             block accepts this cycle
//   Salidas/salidas_validas                   per-channel data {chN-1..ch0} and valid
//   salidas_consumidas                        per-channel consume strobes
//   descartes                                 saturating count of accepted SEL=0 words
module demux_registrado
  import demux_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF,
  parameter int N = N_DEF,
  localparam int NUM_CANALES = 2**N
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ANCHO-1:0]             Entrada,
  input  logic [N-1:0]                 SEL,
  input  logic                         modo_difusion,
  input  logic                         entrada_valida,
  output logic                         entrada_lista,
  output logic [NUM_CANALES*ANCHO-1:0] Salidas,
  output logic [NUM_CANALES-1:0]       salidas_validas,
  input  logic [NUM_CANALES-1:0]       salidas_consumidas,
  output logic [7:0]                   descartes
);
  logic [NUM_CANALES-1:0] libre;
  logic transferencia;
  // channel 0 is the null sink: always free, never valid, zero data; its consume strobe is meaningless
  assign libre[0] = 1'b1 | salidas_consumidas[0];
  assign salidas_validas[0] = 1'b0;
  assign Salidas[ANCHO-1:0] = '0;
  generate
    for (genvar i = 1; i < NUM_CANALES; i++) begin : g_canal
      logic carga;
      assign carga = transferencia && (modo_difusion || SEL == N'(i));
      canal_retencion #(.ANCHO(ANCHO)) u_canal (
        .clk     (clk),
        .rst     (rst),
        .carga   (carga),
        .consumo (salidas_consumidas[i]),
        .entrada (Entrada),
        .dato    (Salidas[i*ANCHO +: ANCHO]),
        .valido  (salidas_validas[i]),
        .libre   (libre[i])
      );
    end
  endgenerate
  // libre[0] is constant 1, so the AND covers exactly channels 1..NUM_CANALES-1 and SEL=0 always accepts
  assign entrada_lista = modo_difusion ? &libre : libre[SEL];
  assign transferencia = entrada_valida && entrada_lista;
  always_ff @(posedge clk or posedge rst)
    if (rst) descartes <= '0;
    else if (transferencia && !modo_difusion && SEL == '0 && descartes != 8'hFF) descartes <= descartes + 8'd1;
endmodule

// File: tb/tb_demux_registrado.sv
module tb_demux_registrado;
  localparam int ANCHO = 9;
  localparam int N = 2;
  localparam int NC = 4;
  logic clk = 0, rst = 1;
  logic [ANCHO-1:0] Entrada = '0;
  logic [N-1:0] SEL = '0;
  logic modo_difusion = 0, entrada_valida = 0;
  logic entrada_lista;
  logic [NC*ANCHO-1:0] Salidas;
  logic [NC-1:0] salidas_validas;
  logic [NC-1:0] salidas_consumidas = '0;
  logic [7:0] descartes;
  int checks = 0, failures = 0;
  int consumidos [NC];
  logic [ANCHO-1:0] sb [NC][$];

  demux_registrado #(.ANCHO(ANCHO), .N(N)) dut (
    .clk(clk), .rst(rst), .Entrada(Entrada), .SEL(SEL), .modo_difusion(modo_difusion),
    .entrada_valida(entrada_valida), .entrada_lista(entrada_lista), .Salidas(Salidas),
    .salidas_validas(salidas_validas), .salidas_consumidas(salidas_consumidas), .descartes(descartes)
  );

  always #5 clk = ~clk;

  // inputs change at posedge+1, so the negedge sees what the next posedge will act on
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 1; i < NC; i++)
        if (salidas_validas[i] && salidas_consumidas[i]) begin
          logic [ANCHO-1:0] esp;
          checks++;
          if (sb[i].size() == 0) begin
            failures++;
            $display("FAIL sb_pop ch%0d: got word %h but no word was expected", i, Salidas[i*ANCHO +: ANCHO]);
          end else begin
            esp = sb[i].pop_front();
            consumidos[i]++;
            if (Salidas[i*ANCHO +: ANCHO] !== esp) begin
              failures++;
              $display("FAIL sb_data ch%0d: got %h expected %h", i, Salidas[i*ANCHO +: ANCHO], esp);
            end
          end
        end
      if (entrada_valida && entrada_lista) begin
        if (modo_difusion) for (int i = 1; i < NC; i++) sb[i].push_back(Entrada);
        else if (SEL != 0) sb[SEL].push_back(Entrada);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (salidas_validas !== 4'b0000 || Salidas !== '0 || descartes !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: validas=%b salidas=%h descartes=%0d expected 0/0/0", salidas_validas, Salidas, descartes);
    end
    SEL = 2;
    entrada_valida = 1;
    #1;
    checks++;
    if (entrada_lista !== 1'b1) begin
      failures++;
      $display("FAIL reset_lista: got %b expected 1", entrada_lista);
    end
    entrada_valida = 0;
    rst = 0;
    step();
  endtask

  task automatic test_unicast();
    Entrada = 9'h0A5;
    SEL = 2;
    entrada_valida = 1;
    step();
    entrada_valida = 0;
    checks++;
    if (salidas_validas !== 4'b0100 || Salidas !== {9'h0, 9'h0A5, 9'h0, 9'h0}) begin
      failures++;
      $display("FAIL unicast: validas=%b salidas=%h expected 0100/%h", salidas_validas, Salidas, {9'h0, 9'h0A5, 9'h0, 9'h0});
    end
  endtask

  task automatic test_backpressure();
    Entrada = 9'h1FF;
    SEL = 2;
    entrada_valida = 1;
    #1;
    checks++;
    if (entrada_lista !== 1'b0) begin
      failures++;
      $display("FAIL bp_lista_full: got %b expected 0", entrada_lista);
    end
    step();
    checks++;
    if (Salidas[26:18] !== 9'h0A5 || salidas_validas !== 4'b0100) begin
      failures++;
      $display("FAIL bp_hold: data=%h validas=%b expected 0a5/0100", Salidas[26:18], salidas_validas);
    end
    salidas_consumidas = 4'b0100;
    #1;
    checks++;
    if (entrada_lista !== 1'b1) begin
      failures++;
      $display("FAIL bp_lista_consume: got %b expected 1", entrada_lista);
    end
    step();
    entrada_valida = 0;
    salidas_consumidas = 0;
    checks++;
    if (salidas_validas !== 4'b0100 || Salidas[26:18] !== 9'h1FF) begin
      failures++;
      $display("FAIL bp_reload: validas=%b data=%h expected 0100/1ff", salidas_validas, Salidas[26:18]);
    end
  endtask

  task automatic test_broadcast();
    salidas_consumidas = 4'b0100;
    step();
    salidas_consumidas = 0;
    Entrada = 9'h155;
    SEL = 3;
    entrada_valida = 1;
    step();
    modo_difusion = 1;
    Entrada = 9'h033;
    SEL = 0;
    #1;
    checks++;
    if (entrada_lista !== 1'b0) begin
      failures++;
      $display("FAIL bc_lista_blocked: got %b expected 0", entrada_lista);
    end
    step();
    checks++;
    if (salidas_validas !== 4'b1000 || Salidas !== {9'h155, 9'h0, 9'h0, 9'h0}) begin
      failures++;
      $display("FAIL bc_no_partial: validas=%b salidas=%h expected 1000/%h", salidas_validas, Salidas, {9'h155, 9'h0, 9'h0, 9'h0});
    end
    salidas_consumidas = 4'b1000;
    #1;
    checks++;
    if (entrada_lista !== 1'b1) begin
      failures++;
      $display("FAIL bc_lista_free: got %b expected 1", entrada_lista);
    end
    step();
    entrada_valida = 0;
    modo_difusion = 0;
    salidas_consumidas = 0;
    checks++;
    if (salidas_validas !== 4'b1110 || Salidas !== {9'h033, 9'h033, 9'h033, 9'h0} || descartes !== 8'd0) begin
      failures++;
      $display("FAIL bc_load: validas=%b salidas=%h descartes=%0d expected 1110/%h/0", salidas_validas, Salidas, descartes, {9'h033, 9'h033, 9'h033, 9'h0});
    end
    salidas_consumidas = 4'b1110;
    step();
    salidas_consumidas = 0;
    checks++;
    if (salidas_validas !== 4'b0000 || Salidas !== '0) begin
      failures++;
      $display("FAIL bc_drain: validas=%b salidas=%h expected 0/0", salidas_validas, Salidas);
    end
  endtask

  task automatic test_descartes();
    SEL = 0;
    entrada_valida = 1;
    for (int k = 1; k <= 260; k++) begin
      Entrada = 9'(k);
      #1;
      checks++;
      if (entrada_lista !== 1'b1) begin
        failures++;
        $display("FAIL desc_lista k=%0d: got %b expected 1", k, entrada_lista);
      end
      step();
      if (k == 100) begin
        checks++;
        if (descartes !== 8'd100) begin
          failures++;
          $display("FAIL desc_mid: got %0d expected 100", descartes);
        end
      end
    end
    entrada_valida = 0;
    checks++;
    if (descartes !== 8'd255 || salidas_validas !== 4'b0000 || Salidas !== '0) begin
      failures++;
      $display("FAIL desc_sat: descartes=%0d validas=%b salidas=%h expected 255/0/0", descartes, salidas_validas, Salidas);
    end
  endtask

  task automatic test_reset_async();
    SEL = 1;
    Entrada = 9'h011;
    entrada_valida = 1;
    step();
    SEL = 3;
    Entrada = 9'h133;
    step();
    entrada_valida = 0;
    checks++;
    if (salidas_validas !== 4'b1010 || Salidas !== {9'h133, 9'h0, 9'h011, 9'h0}) begin
      failures++;
      $display("FAIL ar_loaded: validas=%b salidas=%h expected 1010/%h", salidas_validas, Salidas, {9'h133, 9'h0, 9'h011, 9'h0});
    end
    #2 rst = 1;
    #1;
    checks++;
    if (salidas_validas !== 4'b0000 || Salidas !== '0 || descartes !== 8'd0) begin
      failures++;
      $display("FAIL ar_immediate: validas=%b salidas=%h descartes=%0d expected 0/0/0", salidas_validas, Salidas, descartes);
    end
    for (int i = 0; i < NC; i++) sb[i].delete();
    rst = 0;
    step();
  endtask

  task automatic test_back_to_back();
    int base;
    base = consumidos[1];
    SEL = 1;
    salidas_consumidas = 4'b0010;
    entrada_valida = 1;
    for (int k = 0; k < 16; k++) begin
      Entrada = 9'(k * 29 + 7);
      #1;
      checks++;
      if (entrada_lista !== 1'b1) begin
        failures++;
        $display("FAIL b2b_lista k=%0d: got %b expected 1", k, entrada_lista);
      end
      step();
    end
    entrada_valida = 0;
    step();
    salidas_consumidas = 0;
    checks++;
    if (consumidos[1] - base !== 16 || salidas_validas !== 4'b0000) begin
      failures++;
      $display("FAIL b2b_count: consumed=%0d validas=%b expected 16/0000", consumidos[1] - base, salidas_validas);
    end
  endtask

  initial begin
    for (int i = 0; i < NC; i++) consumidos[i] = 0;
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_descartes();
    test_reset_async();
    test_back_to_back();
    step();
    for (int i = 1; i < NC; i++) begin
      checks++;
      if (sb[i].size() != 0) begin
        failures++;
        $display("FAIL sb_leftover ch%0d: %0d words never consumed, expected 0", i, sb[i].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demux_registrado.md
# demux_registrado

Registered, handshaked successor to the combinational demultiplexor. It steers one ANCHO-bit word per transfer to one of 2**N output channels, or to all channels in broadcast mode. Each channel is backed by a one-entry holding register with its own valid/consume handshake, so a slow consumer no longer loses data. It sits between the microprocessor's internal bus and its destination registers and peripherals. Channel 0 is kept as the null destination, as before.

## Interface
Parameters:
- ANCHO, 9: data word width.
- N, 2: select width; NUM_CANALES = 2**N.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Entrada  in  ANCHO  input word.
- SEL  in  N  destination channel; 0 = discard.
- modo_difusion  in  1  1 = broadcast to channels 1..NUM_CANALES-1, SEL ignored.
- entrada_valida  in  1  Entrada/SEL/modo_difusion are valid this cycle.
- entrada_lista  out  1  block can accept this cycle.
- Salidas  out  NUM_CANALES*ANCHO  concatenated channel data {ch NUM_CANALES-1, …, ch1, ch0}.
- salidas_validas  out  NUM_CANALES  per-channel data valid.
- salidas_consumidas  in  NUM_CANALES  per-channel consumer takes word this cycle.
- descartes  out  8  saturating count of accepted SEL=0 transfers.

## Operation
- Transfer: occurs when entrada_valida && entrada_lista at a rising clk edge.
- Channel i in 1..NUM_CANALES-1 is free when it is not valid, or when it is valid and salidas_consumidas[i]=1 in the same cycle.
- entrada_lista, unicast, SEL≠0: channel SEL is free.
- entrada_lista, unicast, SEL=0: always 1.
- entrada_lista, broadcast: all channels 1..NUM_CANALES-1 are free.
- entrada_lista is combinational from state, SEL, modo_difusion and salidas_consumidas.
- Unicast to SEL≠0: the channel register loads Entrada and its valid bit sets.
- Unicast to SEL=0: the word is dropped and descartes increments, saturating at 255.
- Broadcast: every channel 1..NUM_CANALES-1 loads Entrada and sets valid. descartes is unchanged.
- Consume: valid && salidas_consumidas[i] clears valid and zeroes that channel's data, unless the same edge reloads it.
- salidas_consumidas[i] while not valid: ignored.
- Channel 0: salidas_validas[0]=0 and Salidas slice 0 = 0 at all times.
- Invalid channels always present 0 data, matching the old zero-fill behaviour.
- Per-channel state machine, two states:
  - VACIO: on load → LLENO.
  - LLENO: consume without load → VACIO; consume with load → LLENO with new data; no consume → hold.

## Timing
- Reset: salidas_validas=0, Salidas=0, descartes=0, all channels VACIO. entrada_lista then follows the rules above (1 for any request after reset).
- Reset asserted mid-operation: held words are discarded immediately, without waiting for clk.
- Latency: a word accepted at edge k is visible with valid from just after edge k. It is consumed at the first edge where salidas_consumidas is 1.
- Throughput: one transfer per cycle per channel when the consumer holds salidas_consumidas=1, via same-edge consume+reload.
- Backpressure: when entrada_lista=0, the producer holds inputs stable. No transfer occurs and no state changes except consumes.
- Broadcast is all-or-nothing: no partial loads.

## Structure
- Shared package demux_pkg holds only the default ANCHO=9 and N=2 constants used across the processor. NUM_CANALES is a localparam derived in the block.
- One sub-module, canal_retencion (ANCHO): one-entry register with valid, load, consume, and zero-on-empty. It is instantiated for channels 1..NUM_CANALES-1 via generate.
- Top level contains decode, the entrada_lista logic and the descartes counter.

## Test plan
- Reset, then unicast Entrada=9'h0A5, SEL=2 → next cycle salidas_validas=4'b0100, Salidas[26:18]=9'h0A5, all other slices 0.
- Channel 2 held, salidas_consumidas=0, second word SEL=2 → entrada_lista=0. Then assert salidas_consumidas[2] with word 9'h1FF → same-edge reload, valid stays 1, data=9'h1FF.
- Broadcast 9'h033 with channel 3 full → entrada_lista=0, no channel loads. Then free channel 3 → channels 1..3 all load 9'h033.
- 260 accepted SEL=0 transfers → descartes=255, no channel valid, entrada_lista=1 throughout.
- Channels 1 and 3 full, rst pulsed between edges → salidas_validas=0 and Salidas=0 immediately.
- Continuous unicast to channel 1 with salidas_consumidas[1]=1 → one word per cycle, none lost or duplicated over 16 words.
